vga_frame_scheduler: RTL and testbench
======================================

Name: vga_frame_scheduler

Overview:
- Owns the single VGA adapter write port (x, y, color, writeEn) and shares it between up to three drawing clients: background ROM blitter, cursor sprite and score overlay.
- On each falling edge of V_SYNC it runs the enabled clients strictly in index order (0 first, so higher indices overdraw lower ones).
- It muxes the granted client's pixel stream to the adapter, clips off-screen writes, and flags frame overruns and hung clients.

Parameters:
- SCREEN_W, 320, visible width; writes with x >= SCREEN_W are suppressed.
- SCREEN_H, 240, visible height; writes with y >= SCREEN_H are suppressed.
- TIMEOUT_CYCLES, 81920, maximum cycles a client may hold the grant (17-bit counter).

Ports:
- clk  in  1  system clock.
- iResetn  in  1  asynchronous, active-low reset.
- iVSync  in  1  V_SYNC from the VGA timing; active-low pulse.
- iEnable  in  3  per-client enable; sampled only at frame start.
- iDone  in  3  client i finished its frame (level or pulse).
- iWrite  in  3  client i pixel-write strobe.
- iX  in  27  client i x in bits [9i+8:9i].
- iY  in  24  client i y in bits [8i+7:8i].
- iColor  in  9  client i color in bits [3i+2:3i].
- oStart  out  3  one-cycle start pulse to client i.
- oGrant  out  3  one-hot; client i currently owns the port.
- oX  out  9  adapter x.
- oY  out  8  adapter y.
- oColor  out  3  adapter color.
- oWriteEn  out  1  adapter write enable.
- oBusy  out  1  high whenever the state is not IDLE.
- oOverrun  out  1  sticky; a V_SYNC falling edge arrived while busy.
- oTimeout  out  1  sticky; a client was aborted by the watchdog.

Behaviour:
- Reset (async, iResetn=0):
  - All outputs 0.
  - State IDLE; client index idx=0; enable mask 0.
  - Watchdog counter 0; vsync_prev=0, so a low iVSync right after reset is not an edge.
- Edge detect: vsync_prev <= iVSync every cycle. A frame edge is vsync_prev=1 and iVSync=0.
- State IDLE:
  - On a frame edge, latch mask <= iEnable and go to SELECT.
  - If mask would be 0, stay in IDLE; no pulse is issued.
- State SELECT:
  - Scan from idx for the lowest enabled index.
  - If none remains, set idx=0 and go to IDLE.
  - Otherwise go to START.
  - Takes 1 cycle.
- State START:
  - Drive oStart[idx]=1 for exactly 1 cycle.
  - Set oGrant=one-hot(idx) and clear the watchdog.
  - Go to RUN.
- State RUN:
  - oGrant held.
  - Each cycle, register the client's bus: oX/oY/oColor <= client idx fields.
  - oWriteEn <= iWrite[idx] && x<SCREEN_W && y<SCREEN_H.
  - Forwarding latency is 1 cycle.
  - When iDone[idx]=1: the write sampled in that same cycle is still forwarded; clear mask[idx], idx++, go to SELECT.
  - When the watchdog reaches TIMEOUT_CYCLES-1 without done: set oTimeout, abort the client (mask[idx] cleared, idx++), go to SELECT.
  - Done and timeout in the same cycle: treated as done; oTimeout unchanged.
- Outside RUN:
  - oWriteEn=0 and oGrant=0 (except START, where oGrant is already set).
  - oX/oY/oColor hold their last values.
- Ignored client signals: iDone and iWrite from non-granted clients have no effect.
- Frame edge while not IDLE: set oOverrun. The current frame continues; that edge does not queue another frame.
- iEnable changes mid-frame are ignored until the next frame edge.
- oOverrun and oTimeout clear only on reset.
- Arithmetic: idx is 2 bits. The watchdog saturates at TIMEOUT_CYCLES-1, so it never wraps.

Test Plan:
- Reset then iEnable=3'b001 and a V_SYNC falling edge -> oStart=001 two cycles after the edge. Client writes (5,7,color 3'b110) -> oX=5, oY=7, oColor=6, oWriteEn=1 one cycle later. iDone -> oBusy=0 within 2 cycles.
- iEnable=3'b101 -> client0 runs to done, then client2 gets oStart=100. Client1 never gets oStart or oGrant. Total oStart pulses = 2.
- Client writes x=320,y=10 and x=10,y=240 -> oWriteEn stays 0. x=319,y=239 -> oWriteEn=1.
- Client0 never asserts iDone -> after 81920 cycles in RUN, oTimeout=1 and client1 starts. oTimeout stays 1 through subsequent frames.
- Second V_SYNC falling edge while client0 is still RUN -> oOverrun=1; exactly one frame sequence completes; next edge in IDLE starts normally.
- iResetn pulled low mid-RUN -> outputs 0 immediately (async). After release, no oStart until a new falling edge, even with iVSync held low.

Source files
------------

// File: rtl/vga_frame_scheduler_if.sv
// Shared VGA adapter write port: three client pixel streams in,
// one arbitrated adapter stream plus start/grant handshakes out.
interface vga_frame_scheduler_if;
    logic [2:0]  iDone;
    logic [2:0]  iWrite;
    logic [26:0] iX;
    logic [23:0] iY;
    logic [8:0]  iColor;
    logic [2:0]  oStart;
    logic [2:0]  oGrant;
    logic [8:0]  oX;
    logic [7:0]  oY;
    logic [2:0]  oColor;
    logic        oWriteEn;

    modport slave (
        input  iDone, iWrite, iX, iY, iColor,
        output oStart, oGrant, oX, oY, oColor, oWriteEn
    );

    modport master (
        output iDone, iWrite, iX, iY, iColor,
        input  oStart, oGrant, oX, oY, oColor, oWriteEn
    );
endinterface

// File: rtl/vga_frame_scheduler.sv
// Per-frame scheduler for the VGA write port: runs enabled clients in
// index order after each V_SYNC fall, clips writes, watches for hangs.
module vga_frame_scheduler #(
    parameter int SCREEN_W       = 320,
    parameter int SCREEN_H       = 240,
    parameter int TIMEOUT_CYCLES = 81920
) (
    input  logic                  clk,
    input  logic                  iResetn,
    input  logic                  iVSync,
    input  logic [2:0]            iEnable,
    vga_frame_scheduler_if.slave  bus,
    output logic                  oBusy,
    output logic                  oOverrun,
    output logic                  oTimeout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_START  = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    localparam logic [9:0]  W_LIM  = 10'(SCREEN_W);
    localparam logic [8:0]  H_LIM  = 9'(SCREEN_H);
    localparam logic [16:0] WD_MAX = 17'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  mask_q, mask_d;
    logic [16:0] wd_q, wd_d;
    logic        vs_q;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [2:0]  c_q, c_d;
    logic        we_q, we_d;
    logic        ovr_q, ovr_d;
    logic        to_q, to_d;

    logic        frame_edge;
    logic [2:0]  gnt;
    logic [8:0]  cx;
    logic [7:0]  cy;
    logic [2:0]  cc;
    logic        cwr;
    logic        cdone;
    logic        found;
    logic [1:0]  nidx;

    assign frame_edge = vs_q & ~iVSync;

    always_comb begin
        gnt = 3'b000;
        cx  = bus.iX[8:0];
        cy  = bus.iY[7:0];
        cc  = bus.iColor[2:0];
        unique case (idx_q)
            2'd0: gnt = 3'b001;
            2'd1: begin
                gnt = 3'b010;
                cx  = bus.iX[17:9];
                cy  = bus.iY[15:8];
                cc  = bus.iColor[5:3];
            end
            2'd2: begin
                gnt = 3'b100;
                cx  = bus.iX[26:18];
                cy  = bus.iY[23:16];
                cc  = bus.iColor[8:6];
            end
            default: gnt = 3'b000;
        endcase
    end

    // Only the granted client's strobes matter; others are masked out.
    assign cwr   = |(bus.iWrite & gnt);
    assign cdone = |(bus.iDone & gnt);

    always_comb begin
        found = 1'b0;
        nidx  = idx_q;
        for (int i = 2; i >= 0; i--) begin
            if (mask_q[i] && (2'(i) >= idx_q)) begin
                found = 1'b1;
                nidx  = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        wd_d    = wd_q;
        ovr_d   = ovr_q;
        to_d    = to_q;
        if (frame_edge && (state_q != S_IDLE))
            ovr_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (frame_edge && (iEnable != 3'b000)) begin
                    mask_d  = iEnable;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (found) begin
                    idx_d   = nidx;
                    state_d = S_START;
                end else begin
                    idx_d   = 2'd0;
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cdone || (wd_q == WD_MAX)) begin
                    if (!cdone)
                        to_d = 1'b1;
                    mask_d  = mask_q & ~gnt;
                    idx_d   = idx_q + 2'd1;
                    state_d = S_SELECT;
                end else begin
                    wd_d = wd_q + 17'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        c_d  = c_q;
        we_d = 1'b0;
        if (state_q == S_RUN) begin
            x_d  = cx;
            y_d  = cy;
            c_d  = cc;
            we_d = cwr && ({1'b0, cx} < W_LIM) && ({1'b0, cy} < H_LIM);
        end
    end

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            mask_q  <= 3'b000;
            wd_q    <= '0;
            vs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            we_q    <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            wd_q    <= wd_d;
            vs_q    <= iVSync;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            we_q    <= we_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    assign bus.oStart   = (state_q == S_START) ? gnt : 3'b000;
    assign bus.oGrant   = ((state_q == S_START) || (state_q == S_RUN))
                          ? gnt : 3'b000;
    assign bus.oX       = x_q;
    assign bus.oY       = y_q;
    assign bus.oColor   = c_q;
    assign bus.oWriteEn = we_q;
    assign oBusy        = (state_q != S_IDLE);
    assign oOverrun     = ovr_q;
    assign oTimeout     = to_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler: ordering, clipping,
// watchdog, overrun and async reset, with immediate assertions.
module tb_vga_frame_scheduler;

    logic       clk;
    logic       iResetn;
    logic       iVSync;
    logic [2:0] iEnable;
    logic       oBusy;
    logic       oOverrun;
    logic       oTimeout;

    int vec;
    int bad;
    int starts;
    int g1;
    int n;

    vga_frame_scheduler_if bus ();

    vga_frame_scheduler dut (
        .clk      (clk),
        .iResetn  (iResetn),
        .iVSync   (iVSync),
        .iEnable  (iEnable),
        .bus      (bus),
        .oBusy    (oBusy),
        .oOverrun (oOverrun),
        .oTimeout (oTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        starts = starts + $countones(bus.oStart);
        if (bus.oStart[1] || bus.oGrant[1])
            g1 = g1 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int c, input int x, input int y, input int col);
        bus.iWrite = 3'b000;
        bus.iWrite[c] = 1'b1;
        bus.iX[9*c +: 9] = 9'(x);
        bus.iY[8*c +: 8] = 8'(y);
        bus.iColor[3*c +: 3] = 3'(col);
    endtask

    // Falling V_SYNC; returns in the START cycle.
    task automatic frame_edge();
        iVSync = 1'b0;
        tick();
        iVSync = 1'b1;
        tick();
    endtask

    task automatic finish_client(input int c);
        bus.iDone = 3'b000;
        bus.iDone[c] = 1'b1;
        tick();
        bus.iDone = 3'b000;
        tick();
    endtask

    initial begin
        vec = 0;
        bad = 0;
        starts = 0;
        g1 = 0;
        n = 0;
        iResetn = 1'b0;
        iVSync = 1'b1;
        iEnable = 3'b000;
        bus.iDone = 3'b000;
        bus.iWrite = 3'b000;
        bus.iX = '0;
        bus.iY = '0;
        bus.iColor = '0;
        #3;
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_start", 32'(bus.oStart), 0);
        chk("rst_grant", 32'(bus.oGrant), 0);
        chk("rst_we", 32'(bus.oWriteEn), 0);
        chk("rst_ovr", 32'(oOverrun), 0);
        chk("rst_to", 32'(oTimeout), 0);
        repeat (2) tick();
        iResetn = 1'b1;
        repeat (2) tick();

        // single client, basic forwarding
        iEnable = 3'b001;
        starts = 0;
        iVSync = 1'b0;
        tick();
        chk("t1_busy_sel", 32'(oBusy), 1);
        chk("t1_nostart_yet", 32'(bus.oStart), 0);
        iVSync = 1'b1;
        tick();
        chk("t1_start", 32'(bus.oStart), 32'b001);
        chk("t1_grant", 32'(bus.oGrant), 32'b001);
        tick();
        chk("t1_start_1cyc", 32'(bus.oStart), 0);
        wr(0, 5, 7, 6);
        tick();
        chk("t1_x", 32'(bus.oX), 5);
        chk("t1_y", 32'(bus.oY), 7);
        chk("t1_col", 32'(bus.oColor), 6);
        chk("t1_we", 32'(bus.oWriteEn), 1);
        bus.iWrite = 3'b000;
        bus.iDone = 3'b001;
        tick();
        chk("t1_we_off", 32'(bus.oWriteEn), 0);
        bus.iDone = 3'b000;
        tick();
        chk("t1_idle", 32'(oBusy), 0);
        chk("t1_grant_off", 32'(bus.oGrant), 0);
        chk("t1_x_hold", 32'(bus.oX), 5);

        // clients 0 and 2, client 1 skipped; foreign done ignored
        iEnable = 3'b101;
        starts = 0;
        g1 = 0;
        frame_edge();
        chk("t2_start0", 32'(bus.oStart), 32'b001);
        tick();
        bus.iDone = 3'b010;
        wr(1, 3, 3, 1);
        tick();
        chk("t2_ign_done", 32'(bus.oGrant), 32'b001);
        chk("t2_ign_write", 32'(bus.oWriteEn), 0);
        bus.iDone = 3'b000;
        bus.iWrite = 3'b000;
        finish_client(0);
        chk("t2_start2", 32'(bus.oStart), 32'b100);
        chk("t2_grant2", 32'(bus.oGrant), 32'b100);
        tick();
        finish_client(2);
        chk("t2_idle", 32'(oBusy), 0);
        chk("t2_starts", 32'(starts), 2);
        chk("t2_no_c1", 32'(g1), 0);

        // clipping
        iEnable = 3'b001;
        frame_edge();
        tick();
        wr(0, 320, 10, 1);
        tick();
        chk("t3_clip_x", 32'(bus.oWriteEn), 0);
        wr(0, 10, 240, 1);
        tick();
        chk("t3_clip_y", 32'(bus.oWriteEn), 0);
        wr(0, 319, 239, 5);
        tick();
        chk("t3_edge_we", 32'(bus.oWriteEn), 1);
        chk("t3_edge_x", 32'(bus.oX), 319);
        chk("t3_edge_y", 32'(bus.oY), 239);
        bus.iWrite = 3'b000;
        finish_client(0);
        chk("t3_idle", 32'(oBusy), 0);

        // empty mask stays idle
        iEnable = 3'b000;
        starts = 0;
        frame_edge();
        chk("t3_mask0_busy", 32'(oBusy), 0);
        chk("t3_mask0_starts", 32'(starts), 0);

        // overrun
        iEnable = 3'b001;
        starts = 0;
        frame_edge();
        tick();
        chk("t4_ovr_pre", 32'(oOverrun), 0);
        iVSync = 1'b0;
        tick();
        iVSync = 1'b1;
        chk("t4_ovr", 32'(oOverrun), 1);
        chk("t4_still_grant", 32'(bus.oGrant), 32'b001);
        tick();
        finish_client(0);
        chk("t4_idle", 32'(oBusy), 0);
        repeat (4) tick();
        chk("t4_no_queue", 32'(oBusy), 0);
        chk("t4_starts", 32'(starts), 1);
        frame_edge();
        chk("t4_restart", 32'(bus.oStart), 32'b001);
        tick();
        finish_client(0);
        chk("t4_idle2", 32'(oBusy), 0);

        // watchdog
        iEnable = 3'b011;
        frame_edge();
        tick();
        chk("t5_to_pre", 32'(oTimeout), 0);
        n = 0;
        while (bus.oStart !== 3'b010 && n < 90000) begin
            tick();
            n++;
        end
        chk("t5_to_cycles", 32'(n), 81921);
        chk("t5_to", 32'(oTimeout), 1);
        chk("t5_grant1", 32'(bus.oGrant), 32'b010);
        tick();
        finish_client(1);
        chk("t5_idle", 32'(oBusy), 0);
        iEnable = 3'b001;
        frame_edge();
        tick();
        finish_client(0);
        chk("t5_to_sticky", 32'(oTimeout), 1);

        // async reset mid-RUN
        frame_edge();
        tick();
        wr(0, 1, 2, 3);
        tick();
        chk("t6_we_pre", 32'(bus.oWriteEn), 1);
        iResetn = 1'b0;
        iVSync = 1'b0;
        #1;
        chk("t6_we", 32'(bus.oWriteEn), 0);
        chk("t6_grant", 32'(bus.oGrant), 0);
        chk("t6_busy", 32'(oBusy), 0);
        chk("t6_x", 32'(bus.oX), 0);
        chk("t6_ovr", 32'(oOverrun), 0);
        chk("t6_to", 32'(oTimeout), 0);
        bus.iWrite = 3'b000;
        tick();
        iResetn = 1'b1;
        starts = 0;
        repeat (5) tick();
        chk("t6_no_start_busy", 32'(oBusy), 0);
        chk("t6_no_start", 32'(starts), 0);
        iVSync = 1'b1;
        tick();
        frame_edge();
        chk("t6_restart", 32'(bus.oStart), 32'b001);
        tick();
        finish_client(0);
        chk("t6_idle", 32'(oBusy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
